// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master, one-slave memory bus arbiter. A two-state FSM (IDLE/BUSY) grants
// the bus to one master at a time. When both masters request in the same IDLE
// cycle, the one that was not served last wins (round-robin). In BUSY the
// owner's request is forwarded combinationally to the slave, and the slave's
// completion is returned to the owner in the same cycle.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a busy-cycle watchdog.
// When the owner has been waiting TIMEOUT BUSY cycles, the transfer is forced
// to complete with read data 32'hDEADBEEF and the sticky timeout_err flag is
// set. Without the macro, BUSY waits indefinitely and timeout_err is tied 0.
//
// Parameters:
//   TIMEOUT      busy cycles before forced completion (1..255, macro only)
//
// Ports:
//   clk          rising-edge clock
//   resetn       synchronous active-low reset
//   mN_valid     master N request, held until mN_ready
//   mN_instr     master N instruction-fetch flag
//   mN_addr      master N byte address
//   mN_wstrb     master N write strobes (0 = read)
//   mN_wdata     master N write data
//   mN_ready     one-cycle completion pulse to master N
//   mN_rdata     read data, valid while mN_ready is high (0 otherwise)
//   s_valid      slave request
//   s_instr      slave fetch flag
//   s_addr       slave address
//   s_wstrb      slave write strobes
//   s_wdata      slave write data
//   s_ready      slave completion
//   s_rdata      slave read data
//   owner        index of the granted master, 0 when IDLE
//   timeout_err  sticky forced-completion flag
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        timeout_err
);

  // Elaboration-time range guard for the watchdog limit.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be within 1..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic        last_owner;

  logic        busy;
  logic        own_valid;
  logic        own_instr;
  logic [31:0] own_addr;
  logic [3:0]  own_wstrb;
  logic [31:0] own_wdata;
  logic        tmo_hit;
  logic        xfer_done;
  logic        force_done;
  logic        done;
  logic [31:0] done_rdata;

  assign busy = (state == BUSY);

  // Owner-selected request fields.
  assign own_valid = owner ? m1_valid : m0_valid;
  assign own_instr = owner ? m1_instr : m0_instr;
  assign own_addr  = owner ? m1_addr  : m0_addr;
  assign own_wstrb = owner ? m1_wstrb : m0_wstrb;
  assign own_wdata = owner ? m1_wdata : m0_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  // tmo_cnt counts completed BUSY cycles of the current grant, so it reads
  // TIMEOUT-1 during the TIMEOUT-th BUSY cycle; that cycle is the forced one.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;
  assign tmo_hit = busy && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A dropped owner request wins over everything; a forced completion wins
  // over a slave handshake because s_valid is already withdrawn that cycle.
  assign xfer_done  = busy && own_valid && !tmo_hit && s_ready;
  assign force_done = busy && own_valid && tmo_hit;

  // Completion is combinational so the ready pulse lands in the same cycle as
  // s_ready; gating with resetn keeps an abandoned transfer from completing.
  assign done       = resetn && (xfer_done || force_done);
  assign done_rdata = force_done ? 32'hDEADBEEF : s_rdata;

  assign s_valid = busy && own_valid && !tmo_hit;
  assign s_instr = busy && own_instr;
  assign s_addr  = busy ? own_addr  : 32'h0;
  assign s_wstrb = busy ? own_wstrb : 4'h0;
  assign s_wdata = busy ? own_wdata : 32'h0;

  assign m0_ready = done && !owner;
  assign m1_ready = done && owner;
  assign m0_rdata = m0_ready ? done_rdata : 32'h0;
  assign m1_rdata = m1_ready ? done_rdata : 32'h0;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;  // m0 wins the first tie
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= 8'h0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            state <= BUSY;
            owner <= (m0_valid && m1_valid) ? ~last_owner : m1_valid;
          end
        end
        BUSY: begin
          if (!own_valid) begin
            // Abandoned request: no completion, fairness history untouched.
            state <= IDLE;
            owner <= 1'b0;
          end else if (xfer_done || force_done) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= owner;
          end
        end
        default: begin
          state <= IDLE;
          owner <= 1'b0;
        end
      endcase
`ifdef MEM_ARB_TIMEOUT_EN
      if (busy && own_valid && !xfer_done && !force_done) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end else begin
        tmo_cnt <= 8'h0;
      end
      if (force_done) begin
        timeout_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter. A transaction-level reference model
// (who holds the bus, who was served last, how long the grant has lasted) is
// advanced once per clock and every DUT output is compared against it on the
// falling edge. Directed scenarios add hand-computed literal expectations,
// then a long randomized phase drives both masters and the slave.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int TB_TIMEOUT = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  // Slave latency after s_valid for the single-read scenario; shortened when
  // the watchdog would otherwise fire first.
  localparam int LAT33 = TMO_EN ? 2 : 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mv [2];
  logic        mi [2];
  logic [31:0] ma [2];
  logic [3:0]  ms [2];
  logic [31:0] md [2];
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        owner, timeout_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (mv[0]),
    .m0_instr   (mi[0]),
    .m0_addr    (ma[0]),
    .m0_wstrb   (ms[0]),
    .m0_wdata   (md[0]),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (mv[1]),
    .m1_instr   (mi[1]),
    .m1_addr    (ma[1]),
    .m1_wstrb   (ms[1]),
    .m1_wdata   (md[1]),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_instr    (s_instr),
    .s_addr     (s_addr),
    .s_wstrb    (s_wstrb),
    .s_wdata    (s_wdata),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: transaction-level bookkeeping.
  bit m_busy;     // a grant is outstanding
  bit m_owner;    // holder of the grant
  bit m_last;     // master served last
  bit m_err;      // a forced completion has happened since reset
  int m_cyc;      // 1-based index of the current BUSY cycle
  bit c_ov;       // owner still requesting this cycle
  bit c_tmo;      // this cycle is the watchdog cycle
  bit e_ready [2];

  // Compare all outputs with the model on the falling edge.
  task automatic tick_check();
    bit          done;
    logic        e_sv, e_si;
    logic [31:0] e_sa, e_sd, e_rd;
    logic [3:0]  e_ss;
    @(negedge clk);
    c_ov  = m_busy && mv[m_owner];
    c_tmo = TMO_EN && m_busy && (m_cyc == TB_TIMEOUT);
    done  = c_ov && resetn && (c_tmo || s_ready);
    e_sv  = c_ov && !c_tmo;
    e_si  = m_busy ? mi[m_owner] : 1'b0;
    e_sa  = m_busy ? ma[m_owner] : 32'h0;
    e_ss  = m_busy ? ms[m_owner] : 4'h0;
    e_sd  = m_busy ? md[m_owner] : 32'h0;
    e_rd  = c_tmo ? 32'hDEADBEEF : s_rdata;
    e_ready[0] = done && !m_owner;
    e_ready[1] = done && m_owner;
    check("owner", 128'(owner), 128'(m_busy && m_owner));
    check("s_bus", 128'({s_valid, s_instr, s_addr, s_wstrb, s_wdata}),
          128'({e_sv, e_si, e_sa, e_ss, e_sd}));
    check("m0_resp", 128'({m0_ready, m0_rdata}),
          128'({e_ready[0], e_ready[0] ? e_rd : 32'h0}));
    check("m1_resp", 128'({m1_ready, m1_rdata}),
          128'({e_ready[1], e_ready[1] ? e_rd : 32'h0}));
    check("timeout_err", 128'(timeout_err), 128'(m_err));
  endtask

  // Advance the model with the inputs present at this edge, then cross it.
  task automatic tick_adv();
    if (!resetn) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_err = 0; m_cyc = 0;
    end else if (!m_busy) begin
      if (mv[0] || mv[1]) begin
        m_busy  = 1;
        m_owner = (mv[0] && mv[1]) ? !m_last : mv[1];
        m_cyc   = 1;
      end
    end else if (!c_ov) begin
      m_busy = 0;
    end else if (c_tmo || s_ready) begin
      m_busy = 0;
      m_last = m_owner;
      if (c_tmo) m_err = 1;
    end else begin
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick_check();
    tick_adv();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1;
    mi[i] = 1'($urandom_range(1));
    ma[i] = $urandom;
    ms[i] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
    md[i] = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants [$];
    int m0_served;
    logic [31:0] exp_seq [4];

    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mi[i] = 0; ma[i] = 0; ms[i] = 0; md[i] = 0;
    end
    s_ready = 0;
    s_rdata = 0;
    resetn  = 0;
    tick_adv();          // first edge applies reset to DUT and model
    resetn  = 1;

    // Reset state.
    tick_check();
    check("rst_owner", 128'(owner), 128'(0));
    check("rst_svalid", 128'(s_valid), 128'(0));
    check("rst_err", 128'(timeout_err), 128'(0));
    tick_adv();

    // Single m0 read, slave answers LAT33 cycles after s_valid.
    mv[0] = 1; ma[0] = 32'h0000_0100; ms[0] = 0; md[0] = 0; mi[0] = 0;
    step();
    tick_check();
    check("r33_svalid", 128'(s_valid), 128'(1));
    check("r33_saddr", 128'(s_addr), 128'(32'h0000_0100));
    tick_adv();
    for (int k = 1; k < LAT33; k++) begin
      tick_check();
      check("r33_wait_ready", 128'(m0_ready), 128'(0));
      tick_adv();
    end
    s_ready = 1; s_rdata = 32'h1234_5678;
    tick_check();
    check("r33_m0_ready", 128'(m0_ready), 128'(1));
    check("r33_m0_rdata", 128'(m0_rdata), 128'(32'h1234_5678));
    check("r33_m1_ready", 128'(m1_ready), 128'(0));
    tick_adv();
    mv[0] = 0; s_ready = 0;
    tick_check();
    check("r33_single_pulse", 128'(m0_ready), 128'(0));
    tick_adv();

    // Simultaneous requests after reset: m0 then m1.
    do_reset();
    mv[0] = 1; ma[0] = 32'hA0; mv[1] = 1; ma[1] = 32'hB0;
    step();
    s_ready = 1;
    tick_check();
    check("r34_first_owner", 128'(owner), 128'(0));
    check("r34_m0_ready", 128'(m0_ready), 128'(1));
    tick_adv();
    mv[0] = 0; s_ready = 0;
    step();
    s_ready = 1;
    tick_check();
    check("r34_second_owner", 128'(owner), 128'(1));
    check("r34_m1_ready", 128'(m1_ready), 128'(1));
    tick_adv();
    mv[1] = 0; s_ready = 0;
    step();

    // m1 requests continuously, m0 twice: grants alternate.
    do_reset();
    mv[0] = 1; mv[1] = 1; s_ready = 1;
    m0_served = 0;
    for (int n = 0; n < 10; n++) begin
      tick_check();
      if (m0_ready) grants.push_back(0);
      if (m1_ready) grants.push_back(1);
      if (m0_ready) m0_served++;
      tick_adv();
      if (m0_served == 2) mv[0] = 0;
    end
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
    check("r35_grant_count", 128'(grants.size() >= 4), 128'(1));
    for (int k = 0; k < 4; k++) begin
      if (k < grants.size()) check($sformatf("r35_grant_%0d", k), 128'(grants[k]), 128'(exp_seq[k]));
    end
    mv[1] = 0; s_ready = 0;
    step();

    // m1 write: slave fields follow m1 only while BUSY.
    do_reset();
    mv[1] = 1; ma[1] = 32'hFFFF_0040; ms[1] = 4'b0001; md[1] = 32'h48; mi[1] = 0;
    tick_check();
    check("r36_idle_bus", 128'({s_addr, s_wstrb, s_wdata}), 128'(0));
    tick_adv();
    tick_check();
    check("r36_svalid", 128'(s_valid), 128'(1));
    check("r36_saddr", 128'(s_addr), 128'(32'hFFFF_0040));
    check("r36_swstrb", 128'(s_wstrb), 128'(4'b0001));
    check("r36_swdata", 128'(s_wdata), 128'(32'h48));
    tick_adv();
    s_ready = 1;
    step();
    mv[1] = 0; s_ready = 0;
    tick_check();
    check("r36_idle_after", 128'({s_valid, s_addr, s_wstrb, s_wdata}), 128'(0));
    tick_adv();

    // Owner withdraws in BUSY: no pulse, round-robin history unchanged.
    do_reset();
    mv[0] = 1;
    step();
    step();
    mv[0] = 0;
    tick_check();
    check("r26_abort_svalid", 128'(s_valid), 128'(0));
    check("r26_abort_ready", 128'(m0_ready), 128'(0));
    tick_adv();
    mv[0] = 1; mv[1] = 1;
    step();
    tick_check();
    check("r26_tie_after_abort", 128'(owner), 128'(0));
    tick_adv();
    mv[0] = 0; mv[1] = 0;
    step();
    step();

    // Reset while BUSY abandons the transfer.
    do_reset();
    mv[0] = 1;
    step();
    step();
    resetn = 0;
    tick_check();
    check("r37_no_ready", 128'({m0_ready, m1_ready}), 128'(0));
    tick_adv();
    resetn = 1; mv[0] = 0;
    tick_check();
    check("r37_svalid", 128'(s_valid), 128'(0));
    check("r37_owner", 128'(owner), 128'(0));
    check("r37_ready", 128'(m0_ready), 128'(0));
    tick_adv();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: slave never answers.
    do_reset();
    mv[0] = 1; ma[0] = 32'h40; s_ready = 0;
    step();
    for (int k = 1; k < TB_TIMEOUT; k++) begin
      tick_check();
      check("r38_wait", 128'(m0_ready), 128'(0));
      tick_adv();
    end
    tick_check();
    check("r38_ready", 128'(m0_ready), 128'(1));
    check("r38_rdata", 128'(m0_rdata), 128'(32'hDEADBEEF));
    check("r38_svalid", 128'(s_valid), 128'(0));
    tick_adv();
    mv[0] = 0;
    for (int k = 0; k < 3; k++) begin
      tick_check();
      check("r38_err_sticky", 128'(timeout_err), 128'(1));
      tick_adv();
    end
    do_reset();
    tick_check();
    check("r38_err_cleared", 128'(timeout_err), 128'(0));
    tick_adv();
`endif

    // Randomized traffic checked every cycle against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      s_ready = ($urandom_range(2) == 0);
      s_rdata = $urandom;
      resetn  = ($urandom_range(499) != 0);
      step();
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && e_ready[i]) begin
          mv[i] = 0;
          if ($urandom_range(1) == 1) new_req(i);
        end else if (mv[i]) begin
          if ($urandom_range(39) == 0) mv[i] = 0;
        end else if ($urandom_range(2) == 0) begin
          new_req(i);
        end
      end
    end
    resetn = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
